// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding, command layout and defaults for spi_master
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam int CMD_RD_BIT       = 7;
  localparam int DEFAULT_HALF_DIV = 4;

  function automatic logic [7:0] make_cmd(input logic rd, input logic [6:0] addr7);
    logic [7:0] cmd;
    cmd             = {1'b0, addr7};
    cmd[CMD_RD_BIT] = rd;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host handshake and SPI pin bundle for spi_master
interface spi_master_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        len;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_cs;

  modport master (
    input  start, rd, addr, len, tx_data, tx_valid, spi_miso,
    output tx_ready, rx_data, rx_valid, busy, done, spi_clk, spi_mosi, spi_cs
  );

  modport slave (
    output start, rd, addr, len, tx_data, tx_valid, spi_miso,
    input  tx_ready, rx_data, rx_valid, busy, done, spi_clk, spi_mosi, spi_cs
  );
endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period tick generator; counter restarts from 0 whenever disabled
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int HALF_DIV = DEFAULT_HALF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = 8'd0;
    if (en && cnt_q != LAST) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 register burst master: command byte then len data bytes
// Each byte spans 16 half-periods; the next byte is loaded at the last falling edge of the current one.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_DIV = DEFAULT_HALF_DIV,
  parameter int ADDR_W   = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  spi_state_e state_q, state_d;
  logic       rd_q, rd_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [3:0] hp_q, hp_d;
  logic       stall_q, stall_d;
  logic [7:0] sh_q, sh_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       done_q, done_d;
  logic       spi_clk_q, spi_clk_d;
  logic       spi_cs_q, spi_cs_d;
  logic       tx_ready_c;
  logic       next_exists;
  logic       gen_en;
  logic       tick;
  logic [6:0] addr7;

  if (ADDR_W >= 7) begin : g_addr_trunc
    assign addr7 = bus.addr[6:0];
  end else begin : g_addr_pad
    assign addr7 = {{(7 - ADDR_W){1'b0}}, bus.addr};
  end

  assign gen_en = (state_q != ST_IDLE) && !stall_q;

  spi_clk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_clk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (gen_en),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    byte_cnt_d  = byte_cnt_q;
    hp_d        = hp_q;
    stall_d     = stall_q;
    sh_d        = sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    spi_clk_d   = spi_clk_q;
    spi_cs_d    = spi_cs_q;
    tx_ready_c  = 1'b0;
    // byte_cnt counts data bytes still to start while in CMD, and including the current one in DATA
    next_exists = (state_q == ST_CMD) ? (byte_cnt_q != 8'd0) : (byte_cnt_q > 8'd1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rd_d       = bus.rd;
          byte_cnt_d = bus.len;
          sh_d       = make_cmd(bus.rd, addr7);
          spi_cs_d   = 1'b0;
          hp_d       = 4'd0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          spi_clk_d = 1'b1;
          rx_sh_d   = {rx_sh_q[5:0], bus.spi_miso};
          hp_d      = 4'd0;
          state_d   = ST_CMD;
        end
      end
      ST_CMD, ST_DATA: begin
        if (stall_q) begin
          if (bus.tx_valid) begin
            tx_ready_c = 1'b1;
            sh_d       = bus.tx_data;
            stall_d    = 1'b0;
          end
        end else if (tick) begin
          hp_d = hp_q + 4'd1;
          if (!hp_q[0]) begin
            spi_clk_d = 1'b0;
            if (hp_q == 4'd14) begin
              if (next_exists && !rd_q) begin
                if (bus.tx_valid) begin
                  tx_ready_c = 1'b1;
                  sh_d       = bus.tx_data;
                end else begin
                  stall_d = 1'b1;
                end
              end else begin
                sh_d = 8'd0;
              end
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
            end
          end else if (hp_q == 4'd15) begin
            // End of the trailing low half-period: either the next byte's first rising edge or HOLD
            if (next_exists) begin
              spi_clk_d = 1'b1;
              rx_sh_d   = {rx_sh_q[5:0], bus.spi_miso};
              state_d   = ST_DATA;
              if (state_q == ST_DATA) begin
                byte_cnt_d = byte_cnt_q - 8'd1;
              end
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            spi_clk_d = 1'b1;
            rx_sh_d   = {rx_sh_q[5:0], bus.spi_miso};
            if (state_q == ST_DATA && rd_q && hp_q == 4'd13) begin
              rx_data_d  = {rx_sh_q, bus.spi_miso};
              rx_valid_d = 1'b1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          spi_cs_d = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      byte_cnt_q <= 8'd0;
      hp_q       <= 4'd0;
      stall_q    <= 1'b0;
      sh_q       <= 8'd0;
      rx_sh_q    <= 7'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      spi_clk_q  <= 1'b0;
      spi_cs_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      byte_cnt_q <= byte_cnt_d;
      hp_q       <= hp_d;
      stall_q    <= stall_d;
      sh_q       <= sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      spi_clk_q  <= spi_clk_d;
      spi_cs_q   <= spi_cs_d;
    end
  end

  assign bus.tx_ready = tx_ready_c;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.spi_clk  = spi_clk_q;
  assign bus.spi_mosi = sh_q[7];
  assign bus.spi_cs   = spi_cs_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with a mode-0 slave model
module tb_spi_master;
  import spi_pkg::*;

  localparam int HD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.ADDR_W(7)) bus ();
  spi_master_if #(.ADDR_W(7)) bus1 ();

  spi_master #(.HALF_DIV(HD), .ADDR_W(7)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  spi_master #(.HALF_DIV(1), .ADDR_W(7)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q_mosi[$];
  logic [7:0] q_rx[$];
  int         q_done[$];
  int         q_edges[$];
  int         q_cs_len[$];

  logic [7:0] wr_bytes[256];
  int         wr_gap[256];
  logic [7:0] slave_bytes[256];
  logic       slave_rd = 1'b0;
  bit         stall_probe = 1'b0;

  logic       prev_clk = 1'b0;
  logic       prev_cs = 1'b1;
  int         rise_cnt = 0;
  int         bit_cnt = 0;
  int         cs_low_cnt = 0;
  int         txr_cnt = 0;
  int         k;
  logic [7:0] cur_byte = 8'd0;
  logic [7:0] sb;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor and slave model: everything sampled on the falling clk edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q_mosi.delete(); q_rx.delete(); q_done.delete(); q_edges.delete(); q_cs_len.delete();
      prev_clk = 1'b0; prev_cs = 1'b1;
      rise_cnt = 0; bit_cnt = 0; cs_low_cnt = 0; txr_cnt = 0;
      bus.spi_miso = 1'b0;
    end else begin
      if (!bus.spi_cs && prev_cs) begin
        rise_cnt = 0; bit_cnt = 0; cs_low_cnt = 0;
        bus.spi_miso = 1'b0;
      end
      if (!bus.spi_cs) cs_low_cnt++;
      if (bus.spi_clk && !prev_clk) begin
        if (bus.spi_cs) check("clk_while_cs_high", 1, 0);
        cur_byte = {cur_byte[6:0], bus.spi_mosi};
        rise_cnt++;
        bit_cnt++;
        if (bit_cnt == 8) begin
          bit_cnt = 0;
          if (q_mosi.size() == 0) check("mosi_unexpected_byte", int'(cur_byte), -1);
          else check("mosi_byte", int'(cur_byte), int'(q_mosi.pop_front()));
        end
      end
      if (!bus.spi_clk && prev_clk) begin
        if (slave_rd && rise_cnt >= 8) begin
          k = rise_cnt - 8;
          sb = slave_bytes[k / 8];
          bus.spi_miso = sb[7 - (k % 8)];
        end else begin
          bus.spi_miso = 1'b0;
        end
      end
      if (bus.spi_cs && !prev_cs) begin
        if (q_edges.size() == 0) check("cs_unexpected_frame", 1, 0);
        else begin
          check("rising_edges", rise_cnt, q_edges.pop_front());
          k = q_cs_len.pop_front();
          if (k >= 0) check("cs_low_clks", cs_low_cnt, k);
        end
      end
      if (bus.rx_valid) begin
        if (q_rx.size() == 0) check("rx_unexpected", int'(bus.rx_data), -1);
        else check("rx_data", int'(bus.rx_data), int'(q_rx.pop_front()));
      end
      if (bus.tx_ready) begin
        txr_cnt++;
        if (!bus.tx_valid) check("tx_ready_without_valid", 0, 1);
      end
      if (bus.done) begin
        if (q_done.size() == 0) check("done_unexpected", 1, 0);
        else check("tx_ready_count", txr_cnt, q_done.pop_front());
        check("done_busy_low", int'(bus.busy), 0);
        check("done_cs_high", int'(bus.spi_cs), 1);
        txr_cnt = 0;
      end
      prev_clk = bus.spi_clk;
      prev_cs  = bus.spi_cs;
    end
  end

  task automatic feed(input int n);
    bit got;
    for (int i = 0; i < n; i++) begin
      repeat (wr_gap[i]) @(posedge clk);
      #1;
      if (stall_probe && i > 0) begin
        check("stall_spi_clk_low", int'(bus.spi_clk), 0);
        check("stall_spi_cs_low", int'(bus.spi_cs), 0);
      end
      bus.tx_data  = wr_bytes[i];
      bus.tx_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 5000 && !got; t++) begin
        @(negedge clk);
        if (bus.tx_ready) got = 1'b1;
      end
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      if (!got) check("tx_ready_timeout", 0, 1);
    end
  endtask

  task automatic run_txn(input logic rd_i, input logic [6:0] addr_i, input int len_i,
                         input bit may_stall, input bit poke);
    bit seen;
    q_mosi.push_back(8'(rd_i ? 128 + int'(addr_i) : int'(addr_i)));
    for (int i = 0; i < len_i; i++) q_mosi.push_back(rd_i ? 8'h00 : wr_bytes[i]);
    if (rd_i) for (int i = 0; i < len_i; i++) q_rx.push_back(slave_bytes[i]);
    q_edges.push_back(8 * (len_i + 1));
    q_cs_len.push_back(may_stall ? -1 : HD * (2 + 16 * (len_i + 1)));
    q_done.push_back(rd_i ? 0 : len_i);
    slave_rd = rd_i;
    @(posedge clk);
    #1 bus.start = 1'b1; bus.rd = rd_i; bus.addr = addr_i; bus.len = 8'(len_i);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.rd = ~rd_i; bus.addr = ~addr_i; bus.len = 8'(len_i + 3);
    fork
      begin
        if (!rd_i && len_i > 0) feed(len_i);
      end
      begin
        if (poke) begin
          repeat (10) @(posedge clk);
          #1 bus.start = 1'b1;
          @(posedge clk);
          #1 bus.start = 1'b0;
        end
      end
    join
    seen = 1'b0;
    for (int t = 0; t < 20000 && !seen; t++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("idle_after_done", int'(bus.busy), 0);
  endtask

  logic [7:0]  wb;
  logic [6:0]  a1;
  logic [15:0] sh16;
  logic        p1;
  int          toggles, first_t, last_t, txr1, n_len;
  bit          seen1, any_gap;
  logic        rrd;

  initial begin
    bus.start = 1'b0; bus.rd = 1'b0; bus.addr = 7'd0; bus.len = 8'd0;
    bus.tx_data = 8'd0; bus.tx_valid = 1'b0;
    bus1.start = 1'b0; bus1.rd = 1'b0; bus1.addr = 7'd0; bus1.len = 8'd0;
    bus1.tx_data = 8'd0; bus1.tx_valid = 1'b0; bus1.spi_miso = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_spi_cs", int'(bus.spi_cs), 1);
    check("rst_spi_clk", int'(bus.spi_clk), 0);
    check("rst_spi_mosi", int'(bus.spi_mosi), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_tx_ready", int'(bus.tx_ready), 0);
    check("rst_rx_valid", int'(bus.rx_valid), 0);
    check("rst_rx_data", int'(bus.rx_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write 0x05, data A5 3C, always valid
    wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h3C; wr_gap[0] = 0; wr_gap[1] = 0;
    run_txn(1'b0, 7'h05, 2, 1'b0, 1'b0);

    // Read 0x08, slave returns 11 22 33
    slave_bytes[0] = 8'h11; slave_bytes[1] = 8'h22; slave_bytes[2] = 8'h33;
    run_txn(1'b1, 7'h08, 3, 1'b0, 1'b0);

    // Write with the second byte withheld past its load point
    wr_bytes[0] = 8'($urandom); wr_bytes[1] = 8'($urandom);
    wr_gap[0] = 0; wr_gap[1] = 16 * HD + 20;
    stall_probe = 1'b1;
    run_txn(1'b0, 7'($urandom), 2, 1'b1, 1'b0);
    stall_probe = 1'b0;

    // len=0 read with start pulsed while busy
    run_txn(1'b1, 7'($urandom), 0, 1'b0, 1'b1);

    for (int n = 0; n < 12; n++) begin
      rrd = 1'($urandom_range(0, 1));
      n_len = $urandom_range(0, 5);
      any_gap = 1'b0;
      for (int i = 0; i < 8; i++) begin
        wr_bytes[i] = 8'($urandom);
        slave_bytes[i] = 8'($urandom);
        wr_gap[i] = (i > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : 0;
        if (wr_gap[i] > 0 && i < n_len) any_gap = 1'b1;
      end
      run_txn(rrd, 7'($urandom), n_len, any_gap, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the first data byte of a read
    for (int i = 0; i < 3; i++) slave_bytes[i] = 8'($urandom);
    slave_rd = 1'b1;
    q_mosi.push_back(8'h80 | 8'h12);
    for (int i = 0; i < 3; i++) begin q_mosi.push_back(8'h00); q_rx.push_back(slave_bytes[i]); end
    q_edges.push_back(32); q_cs_len.push_back(-1); q_done.push_back(0);
    @(posedge clk);
    #1 bus.start = 1'b1; bus.rd = 1'b1; bus.addr = 7'h12; bus.len = 8'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (HD * (1 + 16 + 6)) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_spi_cs", int'(bus.spi_cs), 1);
    check("abort_spi_clk", int'(bus.spi_clk), 0);
    check("abort_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_stays_idle", int'(bus.busy), 0);
    for (int i = 0; i < 2; i++) slave_bytes[i] = 8'($urandom);
    run_txn(1'b1, 7'($urandom), 2, 1'b0, 1'b0);

    // HALF_DIV=1 instance: single-byte write
    wb = 8'($urandom); a1 = 7'($urandom);
    bus1.tx_data = wb; bus1.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b1; bus1.rd = 1'b0; bus1.addr = a1; bus1.len = 8'd1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    toggles = 0; first_t = -1; last_t = -1; sh16 = 16'd0; p1 = 1'b0; txr1 = 0; seen1 = 1'b0;
    for (int c = 0; c < 400 && !seen1; c++) begin
      @(negedge clk);
      if (bus1.spi_clk != p1) begin
        toggles++;
        if (first_t < 0) first_t = c;
        last_t = c;
      end
      if (bus1.spi_clk && !p1) sh16 = {sh16[14:0], bus1.spi_mosi};
      if (bus1.tx_ready) txr1++;
      if (bus1.done) seen1 = 1'b1;
      p1 = bus1.spi_clk;
    end
    bus1.tx_valid = 1'b0;
    check("hd1_done", int'(seen1), 1);
    check("hd1_toggles", toggles, 32);
    check("hd1_toggle_span", last_t - first_t, 31);
    check("hd1_stream", int'(sh16), int'({1'b0, a1, wb}));
    check("hd1_tx_ready", txr1, 1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q_mosi.size() + q_rx.size() + q_done.size() + q_edges.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
